// File: rtl/multiport_frontend_pkg.sv
// Shared types and helpers for the multi-port memory request frontend.
package multiport_frontend_pkg;

  // Upper bound on the port count; index-based lookups use vectors padded to this width.
  localparam int MAX_PORTS = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Returns the position of the set bit in a one-hot vector; 0 if none is set.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_PORTS-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/multiport_frontend_rr_arbiter.sv
// Combinational winner search: fixed priority from port 0, or round-robin
// starting at the pointer and wrapping modulo N.
module rr_arbiter
  import multiport_frontend_pkg::*;
#(
  parameter int N       = 4,
  parameter bit RR_MODE = 1'b0
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner
);

  logic [MAX_PORTS-1:0] req_ext;
  logic [IDX_W-1:0]     start;
  logic [IDX_W:0]       cand;
  logic                 found;

  assign req_ext = MAX_PORTS'(req);
  assign start   = RR_MODE ? pointer : '0;

  // Walk the ports from the start position and take the first requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && req_ext[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign grant = (|req) ? (N'(1) << winner) : '0;

endmodule

// File: rtl/multiport_frontend.sv
// N-port request arbiter in front of a single-command memory controller.
// States:
//   IDLE | no grant; arbitrate and latch the winner's command
//   BUSY | command presented to the controller, handshakes routed to grantee
//   HOLD | locked grant kept between ops; only the grantee can issue next
module multiport_frontend
  import multiport_frontend_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter bit RR_MODE   = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_data_wr,
  input  logic [NUM_PORTS-1:0]        port_wr,
  input  logic [NUM_PORTS-1:0]        port_rd,
  input  logic [NUM_PORTS-1:0]        port_burst,
  input  logic [NUM_PORTS-1:0]        port_lock,
  output logic [NUM_PORTS-1:0]        port_grant,
  output logic [NUM_PORTS-1:0]        port_op_begun,
  output logic [NUM_PORTS-1:0]        port_data_ok,
  output logic [NUM_PORTS-1:0]        port_op_finished,
  output logic [NUM_PORTS-1:0]        port_stall,
  input  logic                        op_begun,
  input  logic                        data_ok,
  input  logic                        op_finished,
  output logic [ADDR_W-1:0]           app_addr,
  output logic [DATA_W-1:0]           app_data_out,
  output logic                        app_wr,
  output logic                        app_rd,
  output logic                        app_burst
);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]      app_addr_q, app_addr_d;
  logic [DATA_W-1:0]      app_data_q, app_data_d;
  logic                   app_wr_q, app_wr_d;
  logic                   app_rd_q, app_rd_d;
  logic                   app_burst_q, app_burst_d;

  logic [NUM_PORTS-1:0]   req, arb_grant, latch_oh;
  logic [IDX_W-1:0]       arb_winner, win, sel;
  logic                   load, busy;
  logic [MAX_PORTS-1:0]   req_ext, lock_ext, wr_ext, rd_ext, burst_ext;
  logic [ADDR_W-1:0]      addr_arr [MAX_PORTS];
  logic [DATA_W-1:0]      data_arr [MAX_PORTS];

  assign req       = port_wr | port_rd;
  assign req_ext   = MAX_PORTS'(req);
  assign lock_ext  = MAX_PORTS'(port_lock);
  assign wr_ext    = MAX_PORTS'(port_wr);
  assign rd_ext    = MAX_PORTS'(port_rd);
  assign burst_ext = MAX_PORTS'(port_burst);

  // Unpack per-port address/data into fixed-size arrays so a 3-bit index selects exactly.
  for (genvar g = 0; g < MAX_PORTS; g++) begin : g_unpack
    if (g < NUM_PORTS) begin : g_used
      assign addr_arr[g] = port_addr[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = port_data_wr[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign addr_arr[g] = '0;
      assign data_arr[g] = '0;
    end
  end

  rr_arbiter #(
    .N       (NUM_PORTS),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .winner  (arb_winner)
  );

  assign win = onehot_to_index(MAX_PORTS'(grant_q));

  // Next-state, grant, pointer and command-register update.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    app_addr_d  = app_addr_q;
    app_data_d  = app_data_q;
    app_wr_d    = app_wr_q;
    app_rd_d    = app_rd_q;
    app_burst_d = app_burst_q;
    load        = 1'b0;
    sel         = win;
    case (state_q)
      IDLE: begin
        if (|req) begin
          load    = 1'b1;
          sel     = arb_winner;
          grant_d = arb_grant;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (op_finished) begin
          app_wr_d    = 1'b0;
          app_rd_d    = 1'b0;
          app_burst_d = 1'b0;
          ptr_d       = (win == IDX_W'(NUM_PORTS-1)) ? '0 : win + IDX_W'(1);
          if (lock_ext[win]) begin
            state_d = HOLD;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (req_ext[win]) begin
          load    = 1'b1;
          state_d = BUSY;
        end else if (!lock_ext[win]) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    if (load) begin
      app_addr_d  = addr_arr[sel];
      app_data_d  = data_arr[sel];
      app_wr_d    = wr_ext[sel];
      app_rd_d    = rd_ext[sel];
      app_burst_d = burst_ext[sel];
    end
  end

  // State and command registers; reset abandons any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      app_addr_q  <= '0;
      app_data_q  <= '0;
      app_wr_q    <= 1'b0;
      app_rd_q    <= 1'b0;
      app_burst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      app_addr_q  <= app_addr_d;
      app_data_q  <= app_data_d;
      app_wr_q    <= app_wr_d;
      app_rd_q    <= app_rd_d;
      app_burst_q <= app_burst_d;
    end
  end

  // A port is only released from stall in the cycle its command is latched.
  // Nothing is accepted while reset is held, but the stall outputs are forced low then.
  assign latch_oh = load ? grant_d : '0;
  assign busy     = (state_q == BUSY);

  assign port_grant       = grant_q;
  assign port_op_begun    = (busy && op_begun)    ? grant_q : '0;
  assign port_data_ok     = (busy && data_ok)     ? grant_q : '0;
  assign port_op_finished = (busy && op_finished) ? grant_q : '0;
  assign port_stall       = reset ? '0 : (req & ~latch_oh);

  assign app_addr     = app_addr_q;
  assign app_data_out = app_data_q;
  assign app_wr       = app_wr_q;
  assign app_rd       = app_rd_q;
  assign app_burst    = app_burst_q;

endmodule

// File: tb/tb_multiport_frontend.sv
// Directed bench: one fixed-priority and one round-robin instance share stimulus.
module tb_multiport_frontend;

  localparam int NP = 4;
  localparam int AW = 23;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_data_wr;
  logic [NP-1:0]    port_wr, port_rd, port_burst, port_lock;
  logic             op_begun, data_ok, op_finished;

  logic [NP-1:0] fp_grant, fp_begun, fp_dok, fp_fin, fp_stall;
  logic [AW-1:0] fp_addr;
  logic [DW-1:0] fp_data;
  logic          fp_wr, fp_rd, fp_burst;

  logic [NP-1:0] rr_grant, rr_begun, rr_dok, rr_fin, rr_stall;
  logic [AW-1:0] rr_addr;
  logic [DW-1:0] rr_data;
  logic          rr_wr, rr_rd, rr_burst;

  int total = 0;
  int bad = 0;

  multiport_frontend #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .port_addr(port_addr), .port_data_wr(port_data_wr),
    .port_wr(port_wr), .port_rd(port_rd), .port_burst(port_burst), .port_lock(port_lock),
    .port_grant(fp_grant), .port_op_begun(fp_begun), .port_data_ok(fp_dok),
    .port_op_finished(fp_fin), .port_stall(fp_stall),
    .op_begun(op_begun), .data_ok(data_ok), .op_finished(op_finished),
    .app_addr(fp_addr), .app_data_out(fp_data),
    .app_wr(fp_wr), .app_rd(fp_rd), .app_burst(fp_burst)
  );

  multiport_frontend #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .port_addr(port_addr), .port_data_wr(port_data_wr),
    .port_wr(port_wr), .port_rd(port_rd), .port_burst(port_burst), .port_lock(port_lock),
    .port_grant(rr_grant), .port_op_begun(rr_begun), .port_data_ok(rr_dok),
    .port_op_finished(rr_fin), .port_stall(rr_stall),
    .op_begun(op_begun), .data_ok(data_ok), .op_finished(op_finished),
    .app_addr(rr_addr), .app_data_out(rr_data),
    .app_wr(rr_wr), .app_rd(rr_rd), .app_burst(rr_burst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    port_addr    = '0;
    port_data_wr = '0;
    port_wr      = '0;
    port_rd      = '0;
    port_burst   = '0;
    port_lock    = '0;
    op_begun     = 1'b0;
    data_ok      = 1'b0;
    op_finished  = 1'b0;
  endtask

  task automatic set_port(input int p, input logic wr, input logic rd, input logic burst,
                          input logic lock, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    port_wr[p]              = wr;
    port_rd[p]              = rd;
    port_burst[p]           = burst;
    port_lock[p]            = lock;
    port_addr[p*AW +: AW]   = addr;
    port_data_wr[p*DW +: DW] = data;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({fp_grant, fp_stall, fp_wr, fp_rd, fp_burst} !== 11'd0) begin
      bad++; $display("FAIL reset_fp_ctrl got=%b exp=0", {fp_grant, fp_stall, fp_wr, fp_rd, fp_burst});
    end
    total++;
    if ({fp_addr, fp_data} !== '0) begin
      bad++; $display("FAIL reset_fp_cmd got=%h exp=0", {fp_addr, fp_data});
    end
    total++;
    if ({rr_grant, rr_stall, rr_wr, rr_rd, rr_burst, rr_addr, rr_data} !== '0) begin
      bad++; $display("FAIL reset_rr_outputs got=%h exp=0", {rr_grant, rr_stall, rr_wr, rr_rd, rr_burst, rr_addr, rr_data});
    end
    // Controller handshakes in IDLE must not reach any port.
    op_begun = 1'b1; data_ok = 1'b1; op_finished = 1'b1;
    #1;
    total++;
    if ({fp_begun, fp_dok, fp_fin, rr_begun, rr_dok, rr_fin} !== '0) begin
      bad++; $display("FAIL idle_handshake got=%h exp=0", {fp_begun, fp_dok, fp_fin, rr_begun, rr_dok, rr_fin});
    end
    tick();
    total++;
    if ({fp_grant, rr_grant} !== 8'd0) begin
      bad++; $display("FAIL idle_no_grant got=%b exp=0", {fp_grant, rr_grant});
    end
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    set_port(2, 1'b1, 1'b0, 1'b0, 1'b0, 23'h70F0F0, 16'hBEEF);
    #1;
    total++;
    if (fp_stall !== 4'b0000) begin
      bad++; $display("FAIL single_stall_latch got=%b exp=0000", fp_stall);
    end
    tick();
    total++;
    if ({fp_grant, fp_wr, fp_rd, fp_addr, fp_data} !== {4'b0100, 1'b1, 1'b0, 23'h70F0F0, 16'hBEEF}) begin
      bad++; $display("FAIL single_cmd got=%b/%b/%b/%h/%h exp=0100/1/0/70f0f0/beef",
                      fp_grant, fp_wr, fp_rd, fp_addr, fp_data);
    end
    total++;
    if (fp_stall !== 4'b0100) begin
      bad++; $display("FAIL single_stall_busy got=%b exp=0100", fp_stall);
    end
    op_finished = 1'b1;
    #1;
    total++;
    if ({fp_fin, fp_begun} !== {4'b0100, 4'b0000}) begin
      bad++; $display("FAIL single_finish got=%b begun=%b exp=0100/0000", fp_fin, fp_begun);
    end
    tick();
    op_finished = 1'b0;
    set_port(2, 1'b0, 1'b0, 1'b0, 1'b0, 23'h70F0F0, 16'hBEEF);
    #1;
    total++;
    if ({fp_grant, fp_wr} !== 5'd0) begin
      bad++; $display("FAIL single_release got=%b/%b exp=0000/0", fp_grant, fp_wr);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000001, 16'h0011);
    set_port(3, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000003, 16'h0033);
    #1;
    total++;
    if (fp_stall !== 4'b1000) begin
      bad++; $display("FAIL fp_stall_arb got=%b exp=1000", fp_stall);
    end
    tick();
    total++;
    if ({fp_grant, fp_addr} !== {4'b0010, 23'h000001}) begin
      bad++; $display("FAIL fp_first got=%b/%h exp=0010/000001", fp_grant, fp_addr);
    end
    tick();
    total++;
    if (fp_stall[3] !== 1'b1) begin
      bad++; $display("FAIL fp_stall3_busy got=%b exp=1", fp_stall[3]);
    end
    op_finished = 1'b1;
    tick();
    op_finished = 1'b0;
    set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    #1;
    total++;
    if ({fp_grant, fp_stall} !== {4'b0000, 4'b0000}) begin
      bad++; $display("FAIL fp_bubble got=%b stall=%b exp=0000/0000", fp_grant, fp_stall);
    end
    tick();
    total++;
    if ({fp_grant, fp_addr, fp_wr} !== {4'b1000, 23'h000003, 1'b1}) begin
      bad++; $display("FAIL fp_second got=%b/%h/%b exp=1000/000003/1", fp_grant, fp_addr, fp_wr);
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp_seq [4];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b1000;
    exp_seq[3] = 4'b0001;
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000100, 16'h0100);
    set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000101, 16'h0101);
    set_port(3, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000103, 16'h0103);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (rr_grant !== exp_seq[i]) begin
        bad++; $display("FAIL rr_order_%0d got=%b exp=%b", i, rr_grant, exp_seq[i]);
      end
      op_finished = 1'b1;
      tick();
      op_finished = 1'b0;
      #1;
      total++;
      if (rr_grant !== 4'b0000) begin
        bad++; $display("FAIL rr_bubble_%0d got=%b exp=0000", i, rr_grant);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h111111, 16'h1111);
    set_port(2, 1'b1, 1'b0, 1'b0, 1'b0, 23'h2AAAAA, 16'h2222);
    tick();
    total++;
    if ({fp_grant, fp_addr} !== {4'b0001, 23'h111111}) begin
      bad++; $display("FAIL lock_first got=%b/%h exp=0001/111111", fp_grant, fp_addr);
    end
    op_finished = 1'b1;
    tick();
    op_finished = 1'b0;
    set_port(0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h111111, 16'h1111);
    #1;
    total++;
    if ({fp_grant, fp_wr, fp_rd, fp_stall} !== {4'b0001, 1'b0, 1'b0, 4'b0100}) begin
      bad++; $display("FAIL lock_hold got=%b/%b/%b stall=%b exp=0001/0/0/0100", fp_grant, fp_wr, fp_rd, fp_stall);
    end
    tick();
    total++;
    if ({fp_grant, fp_wr} !== {4'b0001, 1'b0}) begin
      bad++; $display("FAIL lock_hold_stay got=%b/%b exp=0001/0", fp_grant, fp_wr);
    end
    set_port(0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h222222, 16'h0000);
    #1;
    total++;
    if (fp_stall !== 4'b0100) begin
      bad++; $display("FAIL lock_hold_latch_stall got=%b exp=0100", fp_stall);
    end
    tick();
    total++;
    if ({fp_grant, fp_rd, fp_wr, fp_addr} !== {4'b0001, 1'b1, 1'b0, 23'h222222}) begin
      bad++; $display("FAIL lock_second got=%b/%b/%b/%h exp=0001/1/0/222222", fp_grant, fp_rd, fp_wr, fp_addr);
    end
    op_finished = 1'b1;
    tick();
    op_finished = 1'b0;
    set_port(0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
    #1;
    total++;
    if ({fp_grant, fp_rd} !== {4'b0001, 1'b0}) begin
      bad++; $display("FAIL lock_hold2 got=%b/%b exp=0001/0", fp_grant, fp_rd);
    end
    tick();
    total++;
    if (fp_grant !== 4'b0000) begin
      bad++; $display("FAIL lock_drop_idle got=%b exp=0000", fp_grant);
    end
    tick();
    total++;
    if ({fp_grant, fp_addr, fp_data} !== {4'b0100, 23'h2AAAAA, 16'h2222}) begin
      bad++; $display("FAIL lock_port2 got=%b/%h/%h exp=0100/2aaaaa/2222", fp_grant, fp_addr, fp_data);
    end
  endtask

  task automatic test_burst();
    logic [7:0] pat;
    int cnt;
    pat = 8'b1011_0100;
    cnt = 0;
    do_reset();
    set_port(1, 1'b0, 1'b1, 1'b1, 1'b0, 23'h0ABCDE, 16'h0000);
    tick();
    total++;
    if ({fp_grant, fp_rd, fp_burst, fp_addr} !== {4'b0010, 1'b1, 1'b1, 23'h0ABCDE}) begin
      bad++; $display("FAIL burst_cmd got=%b/%b/%b/%h exp=0010/1/1/0abcde", fp_grant, fp_rd, fp_burst, fp_addr);
    end
    for (int i = 0; i < 8; i++) begin
      data_ok = pat[i];
      #1;
      total++;
      if (fp_dok !== (pat[i] ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL burst_dok_%0d got=%b exp=%b", i, fp_dok, (pat[i] ? 4'b0010 : 4'b0000));
      end
      if (fp_dok[1] === 1'b1) cnt++;
      tick();
    end
    data_ok = 1'b0;
    total++;
    if (cnt != 4) begin
      bad++; $display("FAIL burst_count got=%0d exp=4", cnt);
    end
    op_begun = 1'b1;
    op_finished = 1'b1;
    #1;
    total++;
    if ({fp_begun, fp_fin} !== {4'b0010, 4'b0010}) begin
      bad++; $display("FAIL begun_finish_same got=%b/%b exp=0010/0010", fp_begun, fp_fin);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if ({fp_grant, fp_rd, fp_burst} !== 6'd0) begin
      bad++; $display("FAIL burst_release got=%b/%b/%b exp=0000/0/0", fp_grant, fp_rd, fp_burst);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000AAA, 16'h0AAA);
    set_port(2, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000CCC, 16'h0CCC);
    tick();
    op_finished = 1'b1;
    tick();
    op_finished = 1'b0;
    tick();
    total++;
    if ({rr_grant, rr_addr} !== {4'b0100, 23'h000CCC}) begin
      bad++; $display("FAIL rst_pre_grant got=%b/%h exp=0100/000ccc", rr_grant, rr_addr);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({rr_grant, rr_stall, rr_wr, rr_rd, rr_burst, rr_addr, rr_data} !== '0) begin
      bad++; $display("FAIL rst_async got=%h exp=0", {rr_grant, rr_stall, rr_wr, rr_rd, rr_burst, rr_addr, rr_data});
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({rr_grant, rr_addr} !== {4'b0001, 23'h000AAA}) begin
      bad++; $display("FAIL rst_ptr_zero got=%b/%h exp=0001/000aaa", rr_grant, rr_addr);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_burst();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
